// File: rtl/pipe_stage_reg.sv
// Generic Y86 inter-stage pipeline register with stall/bubble control,
// a valid bit, saturating stall/bubble counters and a sticky conflict flag.
module pipe_stage_reg #(
  parameter int                  STAT_W      = 3,
  parameter int                  ICODE_W     = 4,
  parameter int                  IFUN_W      = 4,
  parameter int                  REG_W       = 4,
  parameter int                  DATA_W      = 64,
  parameter logic [ICODE_W-1:0]  NOP_ICODE   = 4'h1,
  parameter logic [IFUN_W-1:0]   NOP_IFUN    = 4'h0,
  parameter logic [STAT_W-1:0]   BUBBLE_STAT = 3'h1,
  parameter int                  CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               bubble,
  input  logic               clr_cnt,
  input  logic               in_valid,
  input  logic [STAT_W-1:0]  in_stat,
  input  logic [ICODE_W-1:0] in_icode,
  input  logic [IFUN_W-1:0]  in_ifun,
  input  logic [REG_W-1:0]   in_rA,
  input  logic [REG_W-1:0]   in_rB,
  input  logic [DATA_W-1:0]  in_valC,
  input  logic [DATA_W-1:0]  in_valP,
  output logic               out_valid,
  output logic [STAT_W-1:0]  out_stat,
  output logic [ICODE_W-1:0] out_icode,
  output logic [IFUN_W-1:0]  out_ifun,
  output logic [REG_W-1:0]   out_rA,
  output logic [REG_W-1:0]   out_rB,
  output logic [DATA_W-1:0]  out_valC,
  output logic [DATA_W-1:0]  out_valP,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic               conflict
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               valid_q, valid_d;
  logic [STAT_W-1:0]  stat_q, stat_d;
  logic [ICODE_W-1:0] icode_q, icode_d;
  logic [IFUN_W-1:0]  ifun_q, ifun_d;
  logic [REG_W-1:0]   rA_q, rA_d;
  logic [REG_W-1:0]   rB_q, rB_d;
  logic [DATA_W-1:0]  valC_q, valC_d;
  logic [DATA_W-1:0]  valP_q, valP_d;
  logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]   bubbleCnt_q, bubbleCnt_d;
  logic               conflict_q, conflict_d;

  // Payload: stall holds, bubble loads the NOP image, otherwise load inputs.
  always_comb begin
    valid_d = valid_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    rA_d    = rA_q;
    rB_d    = rB_q;
    valC_d  = valC_q;
    valP_d  = valP_q;
    if (!stall) begin
      if (bubble) begin
        valid_d = 1'b0;
        stat_d  = BUBBLE_STAT;
        icode_d = NOP_ICODE;
        ifun_d  = NOP_IFUN;
        rA_d    = '1;
        rB_d    = '1;
        valC_d  = '0;
        valP_d  = '0;
      end else begin
        valid_d = in_valid;
        stat_d  = in_stat;
        icode_d = in_icode;
        ifun_d  = in_ifun;
        rA_d    = in_rA;
        rB_d    = in_rB;
        valC_d  = in_valC;
        valP_d  = in_valP;
      end
    end
  end

  // Only an un-stalled bubble actually inserts a NOP, so only that is counted.
  always_comb begin
    stallCnt_d  = stallCnt_q;
    bubbleCnt_d = bubbleCnt_q;
    conflict_d  = conflict_q;
    if (clr_cnt) begin
      stallCnt_d  = '0;
      bubbleCnt_d = '0;
      conflict_d  = 1'b0;
    end else begin
      if (stall && (stallCnt_q != CNT_MAX))
        stallCnt_d = stallCnt_q + CNT_W'(1);
      if (bubble && !stall && (bubbleCnt_q != CNT_MAX))
        bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
      if (stall && bubble)
        conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      stat_q      <= BUBBLE_STAT;
      icode_q     <= NOP_ICODE;
      ifun_q      <= NOP_IFUN;
      rA_q        <= '1;
      rB_q        <= '1;
      valC_q      <= '0;
      valP_q      <= '0;
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
      conflict_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      stat_q      <= stat_d;
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      rA_q        <= rA_d;
      rB_q        <= rB_d;
      valC_q      <= valC_d;
      valP_q      <= valP_d;
      stallCnt_q  <= stallCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
      conflict_q  <= conflict_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_stat   = stat_q;
  assign out_icode  = icode_q;
  assign out_ifun   = ifun_q;
  assign out_rA     = rA_q;
  assign out_rB     = rB_q;
  assign out_valC   = valC_q;
  assign out_valP   = valP_q;
  assign stall_cnt  = stallCnt_q;
  assign bubble_cnt = bubbleCnt_q;
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a default-width instance and a
// CNT_W=4 instance share stimulus so counter saturation can be exercised.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } payload_t;

  typedef struct packed {
    payload_t    p;
    payload_t    p4;
    logic [15:0] sc;
    logic [15:0] bc;
    logic [3:0]  sc4;
    logic [3:0]  bc4;
    logic        conf;
    logic        conf4;
  } obs_t;

  localparam payload_t NOP = '{valid: 1'b0, stat: 3'h1, icode: 4'h1, ifun: 4'h0,
                               rA: 4'hF, rB: 4'hF, valC: 64'h0, valP: 64'h0};

  logic        clk = 1'b0;
  logic        rst_n, stall, bubble, clr_cnt, in_valid;
  logic [2:0]  in_stat;
  logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC, in_valP;

  logic        out_valid, out_valid4;
  logic [2:0]  out_stat, out_stat4;
  logic [3:0]  out_icode, out_ifun, out_rA, out_rB;
  logic [3:0]  out_icode4, out_ifun4, out_rA4, out_rB4;
  logic [63:0] out_valC, out_valP, out_valC4, out_valP4;
  logic [15:0] stall_cnt, bubble_cnt;
  logic [3:0]  stall_cnt4, bubble_cnt4;
  logic        conflict, conflict4;

  int checks = 0;
  int errors = 0;

  obs_t     sb[$];
  payload_t mP;
  logic [15:0] mSc, mBc;
  logic [3:0]  mSc4, mBc4;
  logic        mConf;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC), .in_valP(in_valP),
    .out_valid(out_valid), .out_stat(out_stat), .out_icode(out_icode), .out_ifun(out_ifun),
    .out_rA(out_rA), .out_rB(out_rB), .out_valC(out_valC), .out_valP(out_valP),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .conflict(conflict)
  );

  pipe_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC), .in_valP(in_valP),
    .out_valid(out_valid4), .out_stat(out_stat4), .out_icode(out_icode4), .out_ifun(out_ifun4),
    .out_rA(out_rA4), .out_rB(out_rB4), .out_valC(out_valC4), .out_valP(out_valP4),
    .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4), .conflict(conflict4)
  );

  function automatic obs_t sample();
    obs_t o;
    o.p     = '{out_valid, out_stat, out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP};
    o.p4    = '{out_valid4, out_stat4, out_icode4, out_ifun4, out_rA4, out_rB4, out_valC4, out_valP4};
    o.sc    = stall_cnt;
    o.bc    = bubble_cnt;
    o.sc4   = stall_cnt4;
    o.bc4   = bubble_cnt4;
    o.conf  = conflict;
    o.conf4 = conflict4;
    return o;
  endfunction

  task automatic randIn();
    in_valid = 1'($urandom);
    in_stat  = 3'($urandom);
    in_icode = 4'($urandom);
    in_ifun  = 4'($urandom);
    in_rA    = 4'($urandom);
    in_rB    = 4'($urandom);
    in_valC  = {$urandom, $urandom};
    in_valP  = {$urandom, $urandom};
  endtask

  task automatic setCtl(input logic r, input logic s, input logic b, input logic c);
    rst_n = r; stall = s; bubble = b; clr_cnt = c;
  endtask

  // Advance the reference model with the inputs now driven, queue the
  // expected outputs, then let the edge happen and settle.
  task automatic step();
    obs_t e;
    if (!rst_n) begin
      mP = NOP; mSc = '0; mBc = '0; mSc4 = '0; mBc4 = '0; mConf = 1'b0;
    end else begin
      if (!stall) begin
        if (bubble) mP = NOP;
        else mP = '{in_valid, in_stat, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP};
      end
      if (clr_cnt) begin
        mSc = '0; mBc = '0; mSc4 = '0; mBc4 = '0; mConf = 1'b0;
      end else begin
        if (stall && mSc != 16'hFFFF) mSc = mSc + 16'd1;
        if (stall && mSc4 != 4'hF) mSc4 = mSc4 + 4'd1;
        if (bubble && !stall && mBc != 16'hFFFF) mBc = mBc + 16'd1;
        if (bubble && !stall && mBc4 != 4'hF) mBc4 = mBc4 + 4'd1;
        if (stall && bubble) mConf = 1'b1;
      end
    end
    e = '{p: mP, p4: mP, sc: mSc, bc: mBc, sc4: mSc4, bc4: mBc4, conf: mConf, conf4: mConf};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t a, e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      randIn();
      setCtl(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      step();
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL reset_sb got %h exp %h", a, e); end
    end
    checks++;
    if (a.p !== NOP || a.sc !== 16'd0 || a.bc !== 16'd0 || a.conf !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_image got %h exp %h", a.p, NOP);
    end
  endtask

  task automatic test_load_stall();
    obs_t a, e;
    @(negedge clk);
    randIn();
    in_valid = 1'b1; in_icode = 4'h6; in_rA = 4'h2; in_valC = 64'hDEAD_BEEF;
    setCtl(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL load_sb got %h exp %h", a, e); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      randIn();
      setCtl(1'b1, 1'b1, 1'b0, 1'b0);
      step();
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL stall_sb got %h exp %h", a, e); end
      checks++;
      if (a.p.icode !== 4'h6 || a.p.valC !== 64'hDEAD_BEEF || a.p.rA !== 4'h2 || a.p.valid !== 1'b1) begin
        errors++; $display("[TB] FAIL stall_hold got icode %h valC %h exp 6 deadbeef", a.p.icode, a.p.valC);
      end
    end
    checks++;
    if (a.sc !== 16'd3) begin errors++; $display("[TB] FAIL stall_cnt got %0d exp 3", a.sc); end
    @(negedge clk);
    randIn();
    in_icode = 4'h7; in_valC = 64'h1234_5678_9ABC_DEF0;
    setCtl(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL release_sb got %h exp %h", a, e); end
    checks++;
    if (a.p.icode !== 4'h7 || a.p.valC !== 64'h1234_5678_9ABC_DEF0) begin
      errors++; $display("[TB] FAIL release_load got icode %h valC %h exp 7 123456789abcdef0", a.p.icode, a.p.valC);
    end
  endtask

  task automatic test_bubble();
    obs_t a, e;
    @(negedge clk);
    randIn();
    in_icode = 4'h3; in_valP = 64'h40; in_valid = 1'b1;
    setCtl(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL prebubble_sb got %h exp %h", a, e); end
    @(negedge clk);
    randIn();
    setCtl(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL bubble_sb got %h exp %h", a, e); end
    checks++;
    if (a.p !== NOP || a.bc !== 16'd1) begin
      errors++; $display("[TB] FAIL bubble_nop got %h cnt %0d exp %h cnt 1", a.p, a.bc, NOP);
    end
  endtask

  task automatic test_conflict();
    obs_t a, e;
    payload_t held;
    logic [15:0] sc0, bc0;
    held = mP; sc0 = mSc; bc0 = mBc;
    @(negedge clk);
    randIn();
    setCtl(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL conflict_sb got %h exp %h", a, e); end
    checks++;
    if (a.p !== held || a.sc !== sc0 + 16'd1 || a.bc !== bc0 || a.conf !== 1'b1) begin
      errors++; $display("[TB] FAIL conflict_set got sc %0d bc %0d conf %b exp %0d %0d 1", a.sc, a.bc, a.conf, sc0 + 16'd1, bc0);
    end
    @(negedge clk);
    randIn();
    setCtl(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL sticky_sb got %h exp %h", a, e); end
    checks++;
    if (a.conf !== 1'b1) begin errors++; $display("[TB] FAIL conflict_sticky got %b exp 1", a.conf); end
    held = mP;
    @(negedge clk);
    randIn();
    setCtl(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL clear_sb got %h exp %h", a, e); end
    checks++;
    if (a.sc !== 16'd0 || a.bc !== 16'd0 || a.conf !== 1'b0 || a.p !== held) begin
      errors++; $display("[TB] FAIL clear got sc %0d bc %0d conf %b exp 0 0 0", a.sc, a.bc, a.conf);
    end
  endtask

  task automatic test_saturation();
    obs_t a, e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      randIn();
      setCtl(1'b1, 1'b1, 1'($urandom), 1'b0);
      step();
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL sat_sb got %h exp %h", a, e); end
    end
    checks++;
    if (a.sc4 !== 4'hF || a.sc !== 16'd20) begin
      errors++; $display("[TB] FAIL saturate got sc4 %0d sc %0d exp 15 20", a.sc4, a.sc);
    end
    @(negedge clk);
    setCtl(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL satclr_sb got %h exp %h", a, e); end
    checks++;
    if (a.sc4 !== 4'd0 || a.sc !== 16'd0) begin
      errors++; $display("[TB] FAIL clr_beats_inc got sc4 %0d sc %0d exp 0 0", a.sc4, a.sc);
    end
  endtask

  task automatic test_reset_mid();
    obs_t a, e;
    @(negedge clk);
    randIn(); in_valid = 1'b1;
    setCtl(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL midload_sb got %h exp %h", a, e); end
    @(negedge clk);
    randIn();
    setCtl(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL midstall_sb got %h exp %h", a, e); end
    @(negedge clk);
    randIn();
    setCtl(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL midreset_sb got %h exp %h", a, e); end
    checks++;
    if (a.p !== NOP || a.sc !== 16'd0 || a.conf !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_nop got %h sc %0d exp %h sc 0", a.p, a.sc, NOP);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      randIn();
      setCtl(1'b1, 1'b1, 1'b0, 1'b0);
      step();
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL postreset_sb got %h exp %h", a, e); end
      checks++;
      if (a.p !== NOP) begin errors++; $display("[TB] FAIL nop_holds got %h exp %h", a.p, NOP); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t a, e;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      randIn();
      setCtl(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      step();
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL b2b_sb cycle %0d got %h exp %h", i, a, e); end
    end
  endtask

  initial begin
    setCtl(1'b0, 1'b0, 1'b0, 1'b0);
    randIn();
    test_reset();
    test_load_stall();
    test_bubble();
    test_conflict();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
